// File: rtl/key_matrix_pkg.sv
// Shared types for the key matrix block: event layout, player states and
// Spectrum matrix dimensions.
package key_matrix_pkg;

   localparam int SPECTRUM_ROWS = 8;
   localparam int SPECTRUM_COLS = 5;

   // Index width for a dimension of n entries, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int KEY_RW = idx_w(SPECTRUM_ROWS);
   localparam int KEY_CW = idx_w(SPECTRUM_COLS);

   // Spectrum-sized event; larger matrices use the same field order, wider.
   typedef struct packed {
      logic              pause;
      logic              press;
      logic [KEY_RW-1:0] row;
      logic [KEY_CW-1:0] col;
   } key_ev_t;

   typedef enum logic [1:0] {
      PS_IDLE,
      PS_APPLY,
      PS_WAIT
   } ps_e;

endpackage

// File: rtl/key_ev_fifo.sv
// Show-ahead synchronous FIFO for injection events; wrap-bit pointers give
// full/empty, flush empties it in one cycle and drops a coincident push.
module key_ev_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  level
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk_sys) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/key_matrix_inject.sv
// Active-low key matrix merged from a live layer (scancode events) and an
// injection layer replayed from a paced event queue.
//
// state    | meaning
// PS_IDLE  | waiting for a queued event; pops and loads the pacing counter
// PS_APPLY | applies the latched event to the injection layer (one cycle)
// PS_WAIT  | counts the pacing delay down before the next pop
module key_matrix_inject
   import key_matrix_pkg::*;
#(
   parameter  int ROWS    = SPECTRUM_ROWS,
   parameter  int COLS    = SPECTRUM_COLS,
   parameter  int DEPTH   = 16,
   parameter  int DELAY_W = 24,
   localparam int RW      = idx_w(ROWS),
   localparam int CW      = idx_w(COLS),
   localparam int LW      = $clog2(DEPTH) + 1
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               live_stb,
   input  logic [RW-1:0]      live_row,
   input  logic [CW-1:0]      live_col,
   input  logic               live_press,
   input  logic               release_all,
   input  logic               inj_valid,
   output logic               inj_ready,
   input  logic               inj_pause,
   input  logic [RW-1:0]      inj_row,
   input  logic [CW-1:0]      inj_col,
   input  logic               inj_press,
   input  logic               inj_abort,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [ROWS-1:0]    row_sel_n,
   output logic [COLS-1:0]    key_data,
   output logic               inj_busy,
   output logic [LW-1:0]      inj_level
);

   localparam int RN = 1 << RW;
   localparam int CN = 1 << CW;

   typedef struct packed {
      logic          pause;
      logic          press;
      logic [RW-1:0] row;
      logic [CW-1:0] col;
   } ev_t;

   logic [ROWS-1:0][COLS-1:0] live_q;
   logic [ROWS-1:0][COLS-1:0] inj_q;
   logic [ROWS-1:0][COLS-1:0] live_mask;
   logic [ROWS-1:0][COLS-1:0] inj_mask;
   logic [RN-1:0]             live_row_dec;
   logic [CN-1:0]             live_col_dec;
   logic [RN-1:0]             inj_row_dec;
   logic [CN-1:0]             inj_col_dec;

   ps_e                state;
   logic [DELAY_W-1:0] cnt;
   ev_t                cur;

   ev_t                fifo_wdata;
   logic [$bits(ev_t)-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;

   assign fifo_wdata = '{pause: inj_pause, press: inj_press, row: inj_row, col: inj_col};
   assign pop        = (state == PS_IDLE) && !fifo_empty && !inj_abort;
   assign inj_ready  = !fifo_full;
   assign inj_busy   = (inj_level != '0) || (state != PS_IDLE);

   key_ev_fifo #(
      .W     ($bits(ev_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (inj_valid),
      .wdata   (fifo_wdata),
      .pop     (pop),
      .flush   (inj_abort),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (inj_level)
   );

   // One-hot decode over the full index range; bits beyond ROWS/COLS are
   // simply never used, so out-of-range events produce an empty mask.
   always_comb begin
      live_row_dec           = '0;
      live_col_dec           = '0;
      inj_row_dec            = '0;
      inj_col_dec            = '0;
      live_row_dec[live_row] = 1'b1;
      live_col_dec[live_col] = 1'b1;
      inj_row_dec[cur.row]   = 1'b1;
      inj_col_dec[cur.col]   = 1'b1;
      live_mask              = '0;
      inj_mask               = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            live_mask[r][c] = live_row_dec[r] & live_col_dec[c];
            inj_mask[r][c]  = inj_row_dec[r] & inj_col_dec[c];
         end
      end
   end

   always_comb begin
      logic [COLS-1:0] acc;
      acc = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (!row_sel_n[r]) acc = acc | live_q[r] | inj_q[r];
      end
      key_data = ~acc;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         live_q <= '0;
      end else if (release_all) begin
         live_q <= '0;
      end else if (live_stb) begin
         live_q <= live_press ? (live_q | live_mask) : (live_q & ~live_mask);
      end
   end

   // Leaving WAIT once cnt reaches 1 gives pop-to-pop spacing of
   // max(cfg_delay,1)+1 clocks.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= PS_IDLE;
         cnt   <= '0;
         cur   <= '0;
         inj_q <= '0;
      end else if (inj_abort) begin
         state <= PS_IDLE;
         cnt   <= '0;
         inj_q <= '0;
      end else begin
         unique case (state)
            PS_IDLE: begin
               if (pop) begin
                  cur   <= ev_t'(fifo_rdata);
                  cnt   <= cfg_delay;
                  state <= PS_APPLY;
               end
            end
            PS_APPLY: begin
               if (!cur.pause) begin
                  inj_q <= cur.press ? (inj_q | inj_mask) : (inj_q & ~inj_mask);
               end
               state <= (cnt > DELAY_W'(1)) ? PS_WAIT : PS_IDLE;
            end
            PS_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt <= DELAY_W'(2)) state <= PS_IDLE;
            end
            default: state <= PS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_matrix_inject.sv
// Directed bench for key_matrix_inject in its Spectrum 8x5 configuration.
module tb_key_matrix_inject;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        live_stb = 1'b0;
   logic [2:0]  live_row = '0;
   logic [2:0]  live_col = '0;
   logic        live_press = 1'b0;
   logic        release_all = 1'b0;
   logic        inj_valid = 1'b0;
   logic        inj_ready;
   logic        inj_pause = 1'b0;
   logic [2:0]  inj_row = '0;
   logic [2:0]  inj_col = '0;
   logic        inj_press = 1'b0;
   logic        inj_abort = 1'b0;
   logic [23:0] cfg_delay = '0;
   logic [7:0]  row_sel_n = 8'hFF;
   logic [4:0]  key_data;
   logic        inj_busy;
   logic [4:0]  inj_level;

   int checks = 0;
   int errors = 0;

   key_matrix_inject dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .live_stb    (live_stb),
      .live_row    (live_row),
      .live_col    (live_col),
      .live_press  (live_press),
      .release_all (release_all),
      .inj_valid   (inj_valid),
      .inj_ready   (inj_ready),
      .inj_pause   (inj_pause),
      .inj_row     (inj_row),
      .inj_col     (inj_col),
      .inj_press   (inj_press),
      .inj_abort   (inj_abort),
      .cfg_delay   (cfg_delay),
      .row_sel_n   (row_sel_n),
      .key_data    (key_data),
      .inj_busy    (inj_busy),
      .inj_level   (inj_level)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic live_ev(input logic [2:0] r, input logic [2:0] c, input logic p);
      live_stb = 1'b1; live_row = r; live_col = c; live_press = p;
      tick();
      live_stb = 1'b0;
   endtask

   task automatic push_ev(input logic pz, input logic [2:0] r, input logic [2:0] c, input logic p);
      inj_valid = 1'b1; inj_pause = pz; inj_row = r; inj_col = c; inj_press = p;
      tick();
      inj_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (inj_busy && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (inj_busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: inj_busy still %b after %0d cycles, need 0", inj_busy, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      row_sel_n = 8'hFE;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL reset_key: got %h need 1f", key_data); end
      checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", inj_ready); end
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", inj_busy); end
      checks++; if (inj_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d need 0", inj_level); end
   endtask

   task automatic test_live();
      row_sel_n = 8'hFE;
      live_ev(3'd0, 3'd1, 1'b1);
      checks++; if (key_data !== 5'h1D) begin errors++; $display("FAIL live_press: got %h need 1d", key_data); end
      row_sel_n = 8'hFD; #1;
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL live_other_row: got %h need 1f", key_data); end
      row_sel_n = 8'hFF; #1;
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL live_no_row: got %h need 1f", key_data); end
      row_sel_n = 8'hFE;
      release_all = 1'b1;
      tick();
      release_all = 1'b0;
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL live_release_all: got %h need 1f", key_data); end
      // release_all beats a simultaneous press
      release_all = 1'b1;
      live_ev(3'd0, 3'd2, 1'b1);
      release_all = 1'b0;
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL live_release_prio: got %h need 1f", key_data); end
      live_ev(3'd0, 3'd5, 1'b1);
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL live_col_oor: got %h need 1f", key_data); end
      live_ev(3'd0, 3'd4, 1'b1);
      checks++; if (key_data !== 5'h0F) begin errors++; $display("FAIL live_col4: got %h need 0f", key_data); end
      live_ev(3'd0, 3'd4, 1'b0);
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL live_col4_up: got %h need 1f", key_data); end
   endtask

   task automatic test_inject_seq();
      int   t_r3_dn, t_r3_up, t_r6_dn, t_idle;
      logic r3, r6;
      t_r3_dn = -1; t_r3_up = -1; t_r6_dn = -1; t_idle = -1;
      cfg_delay = 24'd10;
      for (int c = 0; c < 200 && t_idle < 0; c++) begin
         if (c < 4) begin
            inj_valid = 1'b1;
            inj_pause = (c == 2);
            inj_press = (c != 1);
            inj_row   = (c == 3) ? 3'd6 : 3'd3;
            inj_col   = 3'd0;
         end else begin
            inj_valid = 1'b0;
         end
         tick();
         row_sel_n = 8'hF7; #1; r3 = ~key_data[0];
         row_sel_n = 8'hBF; #1; r6 = ~key_data[0];
         if (r3 && t_r3_dn < 0) t_r3_dn = c;
         if (!r3 && t_r3_dn >= 0 && t_r3_up < 0) t_r3_up = c;
         if (r6 && t_r6_dn < 0) t_r6_dn = c;
         if (t_r6_dn >= 0 && !inj_busy && t_idle < 0) t_idle = c;
      end
      inj_valid = 1'b0;
      checks++; if (t_r3_up - t_r3_dn !== 11) begin errors++; $display("FAIL seq_r3_hold: got %0d need 11", t_r3_up - t_r3_dn); end
      checks++; if (t_r6_dn - t_r3_dn !== 33) begin errors++; $display("FAIL seq_r6_delay: got %0d need 33", t_r6_dn - t_r3_dn); end
      checks++; if (t_idle - t_r6_dn !== 9) begin errors++; $display("FAIL seq_busy_fall: got %0d need 9", t_idle - t_r6_dn); end
   endtask

   task automatic test_fifo_full();
      int acc;
      inj_abort = 1'b1;
      tick();
      inj_abort = 1'b0;
      cfg_delay = 24'd100;
      inj_valid = 1'b1; inj_pause = 1'b1; inj_press = 1'b0; inj_row = '0; inj_col = '0;
      acc = 0;
      for (int i = 0; i < 40 && inj_ready; i++) begin
         acc++;
         tick();
         if (i < 2) begin
            checks++;
            if (inj_level !== 5'd1) begin errors++; $display("FAIL full_level_%0d: got %0d need 1", i, inj_level); end
         end
      end
      checks++; if (acc !== 17) begin errors++; $display("FAIL full_accepted: got %0d need 17", acc); end
      checks++; if (inj_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d need 16", inj_level); end
      checks++; if (inj_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b need 0", inj_ready); end
      tick();
      checks++; if (inj_level !== 5'd16) begin errors++; $display("FAIL full_no_push: got %0d need 16", inj_level); end
      inj_valid = 1'b0;
      inj_abort = 1'b1;
      tick();
      inj_abort = 1'b0;
   endtask

   task automatic test_overlap();
      cfg_delay = 24'd2;
      row_sel_n = 8'hFB;
      live_ev(3'd2, 3'd4, 1'b1);
      checks++; if (key_data !== 5'h0F) begin errors++; $display("FAIL ovl_live_down: got %h need 0f", key_data); end
      push_ev(1'b0, 3'd2, 3'd4, 1'b1);
      push_ev(1'b0, 3'd2, 3'd4, 1'b0);
      wait_idle(50);
      checks++; if (key_data !== 5'h0F) begin errors++; $display("FAIL ovl_inj_up_live_held: got %h need 0f", key_data); end
      live_ev(3'd2, 3'd4, 1'b0);
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL ovl_both_up: got %h need 1f", key_data); end
      push_ev(1'b0, 3'd2, 3'd4, 1'b1);
      wait_idle(50);
      live_ev(3'd2, 3'd4, 1'b0);
      checks++; if (key_data !== 5'h0F) begin errors++; $display("FAIL ovl_live_up_inj_held: got %h need 0f", key_data); end
      push_ev(1'b0, 3'd2, 3'd4, 1'b0);
      wait_idle(50);
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL ovl_inj_up: got %h need 1f", key_data); end
   endtask

   task automatic test_abort();
      cfg_delay = 24'd100;
      row_sel_n = 8'hFD;
      for (int i = 0; i < 6; i++) push_ev(i != 0, 3'd1, 3'd0, 1'b1);
      repeat (3) tick();
      checks++; if (inj_level !== 5'd5) begin errors++; $display("FAIL abort_pre_level: got %0d need 5", inj_level); end
      checks++; if (key_data !== 5'h1E) begin errors++; $display("FAIL abort_pre_key: got %h need 1e", key_data); end
      inj_abort = 1'b1;
      inj_valid = 1'b1; inj_pause = 1'b1;
      tick();
      inj_abort = 1'b0;
      inj_valid = 1'b0;
      checks++; if (inj_level !== 5'd0) begin errors++; $display("FAIL abort_level: got %0d need 0", inj_level); end
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b need 0", inj_busy); end
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL abort_key: got %h need 1f", key_data); end
      checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b need 1", inj_ready); end
      tick();
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b need 0", inj_busy); end
   endtask

   task automatic test_async_reset();
      cfg_delay = 24'd100;
      row_sel_n = 8'h00;
      live_ev(3'd0, 3'd1, 1'b1);
      push_ev(1'b0, 3'd1, 3'd0, 1'b1);
      push_ev(1'b1, 3'd0, 3'd0, 1'b0);
      repeat (4) tick();
      checks++; if (key_data !== 5'h1C) begin errors++; $display("FAIL arst_pre_key: got %h need 1c", key_data); end
      checks++; if (inj_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b need 1", inj_busy); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (key_data !== 5'h1F) begin errors++; $display("FAIL arst_key: got %h need 1f", key_data); end
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b need 0", inj_busy); end
      checks++; if (inj_level !== 5'd0) begin errors++; $display("FAIL arst_level: got %0d need 0", inj_level); end
      checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b need 1", inj_ready); end
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_out_of_range();
      int t_chg;
      logic [4:0] k_chg;
      t_chg = -1;
      k_chg = 5'h1F;
      cfg_delay = 24'd4;
      row_sel_n = 8'hFE;
      for (int c = 0; c < 30 && t_chg < 0; c++) begin
         inj_valid = (c < 2);
         inj_pause = 1'b0; inj_press = 1'b1; inj_row = 3'd0;
         inj_col   = (c == 0) ? 3'd6 : 3'd0;
         tick();
         if (key_data !== 5'h1F) begin
            t_chg = c;
            k_chg = key_data;
         end
      end
      inj_valid = 1'b0;
      checks++; if (t_chg !== 7) begin errors++; $display("FAIL oor_spacing: change at %0d need 7", t_chg); end
      checks++; if (k_chg !== 5'h1E) begin errors++; $display("FAIL oor_key: got %h need 1e", k_chg); end
   endtask

   initial begin
      test_reset();
      test_live();
      test_inject_seq();
      test_fifo_full();
      test_overlap();
      test_abort();
      test_async_reset();
      test_out_of_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
